// File: rtl/inv_shift_sub_key_dec_pkg.sv
// Shared definitions for the AES decryption round stage: FSM encoding, widths
// and the FIPS-197 inverse S-box table with its byte-lookup helpers.
package inv_shift_sub_key_dec_pkg;

  localparam int BYTE_W  = 8;
  localparam int COL_W   = 32;
  localparam int STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } decState_e;

  // Entry n occupies bits [8*(255-n) +: 8], so 0x52 (InvSbox(0x00)) is the MSB.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [BYTE_W-1:0] invSboxLookup(input logic [BYTE_W-1:0] b);
    logic [10:0] lo;
    lo = {~b, 3'b000};
    return INV_SBOX_TBL[lo +: BYTE_W];
  endfunction

  // Byte k of a state lives at bits [127-8k -: 8], i.e. low bit 8*(15-k).
  function automatic logic [BYTE_W-1:0] stateByte(input logic [STATE_W-1:0] s,
                                                  input logic [3:0] k);
    logic [6:0] lo;
    lo = {~k, 3'b000};
    return s[lo +: BYTE_W];
  endfunction

endpackage

// File: rtl/inv_shift_sub_key_dec_sbox.sv
// Combinational FIPS-197 inverse S-box for a single byte.
module aes_inv_sbox
  import inv_shift_sub_key_dec_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] byte_o
);

  assign byte_o = invSboxLookup(byte_i);

endmodule

// File: rtl/inv_shift_sub_key_dec.sv
// Iterative InvShiftRows + InvSubBytes + AddRoundKey stage: four shared
// inverse S-boxes produce one output column per cycle, written in place.
module inv_shift_sub_key_dec
  import inv_shift_sub_key_dec_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_Valid,
  output logic               o_Ready,
  input  logic [STATE_W-1:0] i_Din,
  input  logic [STATE_W-1:0] i_Key,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic [STATE_W-1:0] o_Dout
);

  decState_e          state_q;
  logic [1:0]         col_q;
  logic [STATE_W-1:0] st_q;
  logic [STATE_W-1:0] key_q;
  logic [STATE_W-1:0] dout_q;
  logic [STATE_W-1:0] dout_d;
  logic [BYTE_W-1:0]  sboxIn  [4];
  logic [BYTE_W-1:0]  sboxOut [4];
  logic [COL_W-1:0]   colWord;
  logic               accept;

  // Row r of output column col comes from input column (col - r) mod 4.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      sboxIn[r] = stateByte(st_q, {col_q - 2'(r), 2'(r)});
    end
  end

  for (genvar g = 0; g < 4; g++) begin : gRow
    aes_inv_sbox uSbox (
      .byte_i (sboxIn[g]),
      .byte_o (sboxOut[g])
    );
  end

  always_comb begin
    colWord = {sboxOut[0], sboxOut[1], sboxOut[2], sboxOut[3]}
              ^ key_q[{~col_q, 5'b00000} +: COL_W];
    dout_d  = dout_q;
    dout_d[{~col_q, 5'b00000} +: COL_W] = colWord;
  end

  assign o_Ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && i_Ready));
  assign accept  = i_Valid && o_Ready;
  assign o_Valid = (state_q == DONE);
  assign o_Dout  = dout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      st_q    <= '0;
      key_q   <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            st_q    <= i_Din;
            key_q   <= i_Key;
            col_q   <= 2'd0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          dout_q <= dout_d;
          col_q  <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (i_Ready) begin
            if (i_Valid) begin
              st_q    <= i_Din;
              key_q   <= i_Key;
              col_q   <= 2'd0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_shift_sub_key_dec.sv
// Self-checking bench for inv_shift_sub_key_dec: directed cases plus random
// handshake traffic checked against a GF(2^8)-derived AES reference model.
module tb_inv_shift_sub_key_dec;

  logic         clk;
  logic         rst_n;
  logic         i_Valid;
  logic         o_Ready;
  logic [127:0] i_Din;
  logic [127:0] i_Key;
  logic         o_Valid;
  logic         i_Ready;
  logic [127:0] o_Dout;

  int checks = 0;
  int errors = 0;

  logic [7:0] invS [256];

  inv_shift_sub_key_dec dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_Valid (i_Valid),
    .o_Ready (o_Ready),
    .i_Din   (i_Din),
    .i_Key   (i_Key),
    .o_Valid (o_Valid),
    .i_Ready (i_Ready),
    .o_Dout  (o_Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Forward S-box from its algebraic definition, then inverted into invS.
  task automatic buildTables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      invS[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] getB(input logic [127:0] v, input int k);
    return v[127 - 8*k -: 8];
  endfunction

  function automatic logic [127:0] refDec(input logic [127:0] din, input logic [127:0] key);
    logic [7:0]   s [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = getB(din, 4*c + r);
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = invS[s[r][(c - r + 4) % 4]] ^ getB(key, 4*c + r);
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One isolated block with i_Ready high: checks latency and result.
  task automatic applyStimulus(input string tag, input logic [127:0] din,
                               input logic [127:0] key, input logic [127:0] expected);
    int lat;
    @(negedge clk);
    i_Valid = 1'b1;
    i_Din   = din;
    i_Key   = key;
    i_Ready = 1'b1;
    #1;
    checkOutput({tag, "_ready"}, 128'(o_Ready), 128'd1);
    @(posedge clk);
    #1;
    i_Valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!o_Valid && lat < 20);
    checkOutput({tag, "_latency"}, 128'(lat), 128'd4);
    checkOutput({tag, "_dout"}, o_Dout, expected);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] dinA, keyA, dinB, keyB, expA, expB, din3;
    logic [127:0] expQ [$];
    int stallBad, spurious, lat, sent, recv, cyc;
    logic acceptedLast;

    buildTables();

    rst_n   = 1'b0;
    i_Valid = 1'b0;
    i_Ready = 1'b1;
    i_Din   = '0;
    i_Key   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 128'(o_Ready), 128'd0);
    checkOutput("rst_valid", 128'(o_Valid), 128'd0);
    checkOutput("rst_dout", o_Dout, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_ready", 128'(o_Ready), 128'd1);

    applyStimulus("all63", {16{8'h63}}, 128'd0, 128'd0);
    applyStimulus("keyff", 128'd0, {16{8'hff}}, {16{8'had}});
    din3 = {16{8'h63}};
    din3[119:112] = 8'h00;
    applyStimulus("row1", din3, 128'd0, 128'h00000000_00520000_00000000_00000000);
    dinA = rand128();
    keyA = rand128();
    applyStimulus("rand_single", dinA, keyA, refDec(dinA, keyA));

    // Back-pressure with the next block already waiting on i_Valid.
    dinA = rand128(); keyA = rand128(); expA = refDec(dinA, keyA);
    dinB = rand128(); keyB = rand128(); expB = refDec(dinB, keyB);
    @(negedge clk);
    i_Valid = 1'b1; i_Din = dinA; i_Key = keyA; i_Ready = 1'b0;
    @(posedge clk);
    #1;
    i_Din = dinB; i_Key = keyB;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!o_Valid && lat < 20);
    checkOutput("bp_first_latency", 128'(lat), 128'd4);
    stallBad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_Dout !== expA || o_Ready !== 1'b0 || o_Valid !== 1'b1) stallBad++;
    end
    checkOutput("bp_stall", 128'(stallBad), 128'd0);
    checkOutput("bp_hold_dout", o_Dout, expA);
    @(negedge clk);
    i_Ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 128'(o_Ready), 128'd1);
    @(posedge clk);
    #1;
    i_Valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!o_Valid && lat < 20);
    checkOutput("bp_second_latency", 128'(lat), 128'd4);
    checkOutput("bp_second_dout", o_Dout, expB);
    @(posedge clk);
    #1;

    // Reset while column 2 is the next one to be written.
    @(negedge clk);
    i_Valid = 1'b1; i_Din = rand128(); i_Key = rand128(); i_Ready = 1'b1;
    @(posedge clk);
    #1;
    i_Valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", 128'(o_Valid), 128'd0);
    checkOutput("midrst_dout", o_Dout, 128'd0);
    checkOutput("midrst_ready", 128'(o_Ready), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_Valid) spurious++;
    end
    checkOutput("midrst_spurious", 128'(spurious), 128'd0);
    checkOutput("midrst_idle_ready", 128'(o_Ready), 128'd1);

    // Random traffic: drive at negedge, observe handshakes just before posedge.
    sent = 0; recv = 0; cyc = 0; acceptedLast = 1'b0;
    i_Valid = 1'b0;
    while (recv < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (acceptedLast) i_Valid = 1'b0;
      if (!i_Valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        i_Valid = 1'b1;
        i_Din   = rand128();
        i_Key   = rand128();
      end
      i_Ready = ($urandom_range(0, 3) != 0);
      #1;
      acceptedLast = 1'b0;
      if (o_Valid && i_Ready) begin
        recv++;
        if (expQ.size() > 0) checkOutput("rand_dout", o_Dout, expQ.pop_front());
      end
      if (i_Valid && o_Ready) begin
        expQ.push_back(refDec(i_Din, i_Key));
        sent++;
        acceptedLast = 1'b1;
      end
    end
    @(negedge clk);
    i_Valid = 1'b0;
    checkOutput("rand_sent", 128'(sent), 128'd1000);
    checkOutput("rand_recv", 128'(recv), 128'd1000);
    checkOutput("rand_leftover", 128'(expQ.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
